// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage; owns HI/LO.
// Results are computed at accept and committed after a fixed busy window.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;

    logic             is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Sign-extending to 2*WIDTH makes one unsigned multiplier cover both forms.
    always_comb begin
        is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_ext = is_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_ext = is_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod  = a_ext * b_ext;
    end

    // Magnitude division: MIN/-1 falls out as MIN with zero remainder.
    always_comb begin
        a_neg    = is_signed & A[WIDTH-1];
        b_neg    = is_signed & B[WIDTH-1];
        div_zero = (B == '0);
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
        dsr      = div_zero ? ONE_W : b_mag;
        q_mag    = a_mag / dsr;
        r_mag    = a_mag % dsr;
        quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem      = a_neg ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                pend_hi <= prod[2*WIDTH-1:WIDTH];
                                pend_lo <= prod[WIDTH-1:0];
                                pend_wr <= 1'b1;
                                cnt     <= MUL_CNT;
                                Busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi <= rem;
                                pend_lo <= quo;
                                pend_wr <= !div_zero;
                                cnt     <= DIV_CNT;
                                Busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        pend_wr <= 1'b0;
                        Busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and
// busy length; a monitor checks them when Busy falls.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    md_unit #(
        .WIDTH(32),
        .MULT_LAT(5),
        .DIV_LAT(10),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Start(Start),
        .MDOp(MDOp),
        .A(A),
        .B(B),
        .Busy(Busy),
        .HI(HI),
        .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo,
                        input int lat);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.lat = lat;
        q.push_back(e);
    endtask

    // Accepted on the next rising edge; returns 1ns after it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk);
        #1;
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = 3'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!Busy) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout actual=busy required=idle", name);
    endtask

    // Monitor: a falling Busy is the unit presenting a result.
    initial begin
        int   bc;
        logic pb;
        exp_t e;
        bc = 0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bc = 0;
                pb = 1'b0;
            end else begin
                if (pb && !Busy) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%h_%h required=none",
                                 HI, LO);
                    end else begin
                        e = q.pop_front();
                        chk("sb_hi", HI, e.hi);
                        chk("sb_lo", LO, e.lo);
                        chk("sb_busy_cycles", 32'(bc), 32'(e.lat));
                    end
                    bc = 0;
                end
                if (Busy) bc++;
                pb = Busy;
            end
        end
    end

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult");

        push(32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle("multu");

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div");

        issue(3'd5, 32'h11, 32'd0);
        chk("mthi_hi", HI, 32'h11);
        chk("mthi_lo_kept", LO, 32'hFFFF_FFFD);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        chk("mtlo_lo", LO, 32'h22);
        chk("mtlo_hi_kept", HI, 32'h11);

        push(32'h11, 32'h22, 10);
        issue(3'd4, 32'd7, 32'd0);
        wait_idle("divu_zero");

        push(32'h0, 32'h8000_0000, 10);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        // MTLO held through the whole busy window must wait for idle.
        push(32'h0, 32'h0012_3400, 5);
        issue(3'd1, 32'h1234, 32'h100);
        Start = 1'b1;
        MDOp  = 3'd6;
        A     = 32'h55;
        @(posedge clk);
        #1;
        chk("mtlo_ignored", LO, 32'h8000_0000);
        wait_idle("mult_mtlo");
        chk("mult_lo_final", LO, 32'h0012_3400);
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = 3'd0;
        chk("mtlo_after", LO, 32'h55);
        chk("mtlo_after_busy", {31'd0, Busy}, 32'd0);

        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        issue(3'd0, 32'hDEAD_BEEF, 32'd1);
        chk("none_hi", HI, 32'h0);
        chk("none_lo", LO, 32'h55);
        chk("none_busy", {31'd0, Busy}, 32'd0);

        issue(3'd5, 32'h77, 32'd0);
        chk("mthi2", HI, 32'h77);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        chk("post_rst_hi", HI, 32'd0);
        chk("post_rst_lo", LO, 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the pipelined MIPS core, sitting in the EX stage beside the ALU and owning the HI/LO architectural registers. It executes MULT, MULTU, DIV and DIVU over a configurable number of cycles, performs single-cycle MTHI/MTLO writes, and drives a Busy flag. The hazard logic combines Busy and Start to stall any multiply/divide-class instruction in D.

## Interface
- WIDTH, 32: operand and HI/LO width.
- MULT_LAT, 5: busy cycles for MULT/MULTU; must be ≥1.
- DIV_LAT, 10: busy cycles for DIV/DIVU; must be ≥1.
- CNT_W, 4: counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  EX-stage launch strobe, qualified by MDOp.
- MDOp  input  3  operation select: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- Busy  output  1  operation in flight; HI/LO not yet valid.
- HI  output  WIDTH  HI register (MFHI source).
- LO  output  WIDTH  LO register (MFLO source).

## Operation
- Reset values: Busy=0, HI=0, LO=0, counter=0, pending result=0.
- Accept condition: a rising edge with Start=1 and Busy=0. When Busy=1, Start is ignored entirely, including MTHI/MTLO.
- MULT: {HI,LO} = signed A × signed B, full 2·WIDTH product. MULTU: the unsigned product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend. DIVU: the unsigned equivalents.
- Operands are captured, or the result is computed, at the accept edge. A and B may change afterwards without effect.
- Divide by zero (B=0): the full DIV_LAT busy period still runs; HI and LO keep their prior values.
- Signed overflow (A = most-negative value, B = −1): LO = most-negative value, HI = 0.
- MTHI/MTLO: at the accept edge, HI (or LO) is loaded with A. Busy does not assert, and the other register is unchanged.
- NONE/reserved with Start=1: no effect.
- States:
  - IDLE: Busy=0. A mult/div accept moves to RUN with the counter loaded to MULT_LAT or DIV_LAT.
  - RUN: Busy=1; the counter decrements every edge. On the edge where the counter is 1, HI/LO are written from the pending result, the counter reaches 0, and the unit returns to IDLE.
- Reset asserted in RUN aborts the operation; the pending result is discarded.

## Timing
- Accept at edge E0. Busy is high from after E0 through the cycle before edge E_L (L = MULT_LAT or DIV_LAT), which is exactly L cycles.
- At E_L, HI/LO update and Busy deasserts together. A dependent MFHI/MFLO reading after E_L sees the new value.
- Back-to-back issue: a new Start is accepted at E_L+1 at the earliest. Start presented in the same cycle that Busy is still high (including the final busy cycle) is ignored; upstream stall logic guarantees it is held.
- MTHI/MTLO take effect at the accept edge, so HI/LO show the new value in the next cycle.
- HI and LO are direct register outputs, with no combinational path from A, B or Start.
- Reset is asynchronous: outputs return to reset values immediately on assertion, independent of clk.

## Test plan
- MULT, A=0xFFFFFFFE (−2), B=3, MULT_LAT=5:
  - Busy is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=−7, B=2: after 10 busy cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU, A=7, B=0, with HI=0x11, LO=0x22 preloaded via MTHI/MTLO:
  - Busy runs 10 cycles.
  - HI/LO remain 0x11 and 0x22.
- Start+MTLO A=0x55 issued during the busy window of a MULT:
  - The MTLO is ignored.
  - The final LO is the product.
  - A subsequent MTLO at E_L+1 loads 0x55 the next cycle.
- Reset asserted mid-DIV at busy cycle 4: Busy, HI and LO go to 0 immediately, and no write occurs afterwards.
